// File: rtl/prioritas_kodolo.sv
// Registered priority encoder with sticky pending requests. Requests are served
// highest index first, and each index is held on q/valid until it is acked.
module prioritas_kodolo #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         ack,
   output logic [W-1:0] q,
   output logic         valid,
   output logic         busy
);

   // valid/ready contract: an index on q is offered while valid=1 and retires
   // on a clk edge where ack=1; ack while valid=0 carries no meaning.
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t       state;
   logic [N-1:0] pend;
   logic [N-1:0] src;
   logic [N-1:0] sel;
   logic [N-1:0] rest;
   logic [W-1:0] hi;
   logic         found;
   logic         load;

   assign src   = pend | req;
   assign found = |src;
   assign load  = !valid || ack;

   // Ascending scan so the last hit, i.e. the highest set bit, wins.
   always_comb begin
      hi = '0;
      for (int i = 0; i < N; i++) begin
         if (src[i]) hi = W'(i);
      end
   end

   assign sel  = N'(1) << hi;
   assign rest = src & ~sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pend  <= '0;
         q     <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
      end else if (load) begin
         if (found) begin
            state <= HOLD;
            q     <= hi;
            valid <= 1'b1;
            pend  <= rest;
            busy  <= |rest;
         end else begin
            state <= IDLE;
            valid <= 1'b0;
            pend  <= '0;
            busy  <= 1'b0;
         end
      end else begin
         // Output stalled: new requests only accumulate behind q.
         state <= state;
         pend  <= src;
         busy  <= found;
      end
   end

endmodule

// File: tb/tb_prioritas_kodolo.sv
// Directed bench for prioritas_kodolo (N=8): reset behaviour, single and
// multiple requests, stalls, draining, re-requests and mid-run resets.
module tb_prioritas_kodolo;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic         ack = 1'b0;
   logic [W-1:0] q;
   logic         valid;
   logic         busy;

   int n_checks = 0;
   int n_pass   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] e;

   prioritas_kodolo #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .ack   (ack),
      .q     (q),
      .valid (valid),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic check_out(input string tag, input logic [W-1:0] eq, input logic ev, input logic eb);
      check({tag, "_q"}, 32'(q), 32'(eq));
      check({tag, "_valid"}, 32'(valid), 32'(ev));
      check({tag, "_busy"}, 32'(busy), 32'(eb));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state before any clock edge
      #1;
      check_out("reset", 3'd0, 1'b0, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_out("idle", 3'd0, 1'b0, 1'b0);

      // Single request, acked
      req = 8'b0000_0100; ack = 1'b1;
      tick();
      req = '0;
      check_out("single", 3'd2, 1'b1, 1'b0);
      tick();
      check_out("single_done", 3'd2, 1'b0, 1'b0);

      // Two requests, stalled for 3 cycles
      ack = 1'b0; req = 8'b1000_0001;
      tick();
      req = '0;
      check_out("two_first", 3'd7, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_out("two_stall", 3'd7, 1'b1, 1'b1);
      end
      ack = 1'b1;
      tick();
      check_out("two_second", 3'd0, 1'b1, 1'b0);
      tick();
      check_out("two_done", 3'd0, 1'b0, 1'b0);

      // Full burst drained one index per cycle
      ack = 1'b1; req = 8'hFF;
      for (int i = 7; i >= 0; i--) exp_q.push_back(W'(i));
      tick();
      req = '0;
      repeat (8) begin
         e = exp_q.pop_front();
         check_out("drain", e, 1'b1, (e != 3'd0));
         tick();
      end
      check_out("drain_done", 3'd0, 1'b0, 1'b0);

      // Re-request of the index currently presented
      ack = 1'b0; req = 8'b0010_0000;
      tick();
      req = '0;
      check_out("rereq_first", 3'd5, 1'b1, 1'b0);
      req = 8'b0010_0000;
      tick();
      req = '0;
      check_out("rereq_stored", 3'd5, 1'b1, 1'b1);
      ack = 1'b1;
      tick();
      check_out("rereq_again", 3'd5, 1'b1, 1'b0);
      tick();
      check_out("rereq_done", 3'd5, 1'b0, 1'b0);

      // Asynchronous reset mid-operation with req=FF
      ack = 1'b0; req = 8'hFF;
      tick();
      check_out("mid_run", 3'd7, 1'b1, 1'b1);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_rst", 3'd0, 1'b0, 1'b0);
      req = '0;
      tick();
      check_out("in_rst", 3'd0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b1;
      tick();
      tick();
      check_out("after_rst", 3'd0, 1'b0, 1'b0);

      // Reset while q=4 during a drain
      ack = 1'b1; req = 8'hFF;
      tick();
      req = '0;
      check_out("burst7", 3'd7, 1'b1, 1'b1);
      tick();
      tick();
      tick();
      check_out("burst4", 3'd4, 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("rst_at4", 3'd0, 1'b0, 1'b0);
      tick();
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_out("quiet", 3'd0, 1'b0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
